// File: rtl/riscv_defines.sv
// Shared loader constants and the loader state encoding.
// The program loader and its bench-facing interface import these definitions.
package riscv_defines;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] ACK_BYTE  = 8'h4B;
   localparam logic [7:0] NAK_BYTE  = 8'h45;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      RESP = 3'd4,
      RUN  = 3'd5
   } loader_state_e;

   // States in which an incoming byte stream is expected and may time out.
   function automatic logic state_is_receiving(loader_state_e s);
      return (s == LEN) || (s == DATA) || (s == CSUM);
   endfunction

   function automatic logic state_is_busy(loader_state_e s);
      return state_is_receiving(s) || (s == RESP);
   endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte stream, response and core-programming signals of the UART program loader.
// The loader uses the master modport; its environment uses the slave modport.
interface uart_prog_loader_if;

   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        prog_en;
   logic [31:0] prog_addr;
   logic [31:0] prog_data;
   logic        start;
   logic        busy;

   modport master (
      input  rx_valid, rx_data, tx_ready,
      output tx_valid, tx_data, prog_en, prog_addr, prog_data, start, busy
   );

   modport slave (
      output rx_valid, rx_data, tx_ready,
      input  tx_valid, tx_data, prog_en, prog_addr, prog_data, start, busy
   );

endinterface

// File: rtl/uart_prog_loader_timeout.sv
// Inter-byte timeout: a loadable down-counter reloaded by clear, flagging expiry
// when it has run down to zero while enabled.
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = LOAD_VAL;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Counter reaches zero TIMEOUT_CYCLES cycles after the last clear.
   assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: receives a framed program image (sync, length, words,
// checksum), writes each word to the core, answers ACK/NAK and releases the core.
module uart_prog_loader
   import riscv_defines::*;
#(
   parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 4096,
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
   input  logic                clk,
   input  logic                rstn,
   uart_prog_loader_if.master  bus
);

   loader_state_e state_q, state_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   word_cnt_q, word_cnt_d;
   logic [23:0]   word_q, word_d;
   logic [7:0]    csum_q, csum_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          prog_en_q, prog_en_d;
   logic [31:0]   prog_addr_q, prog_addr_d;
   logic [31:0]   prog_data_q, prog_data_d;

   logic          to_clear;
   logic          to_enable;
   logic          to_expire;
   logic [15:0]   len_full;
   logic [31:0]   word_full;
   logic [15:0]   word_cnt_inc;

   assign len_full     = {bus.rx_data, len_q[7:0]};
   assign word_full    = {bus.rx_data, word_q};
   assign word_cnt_inc = word_cnt_q + 16'd1;

   // NOTE: every _d takes its _q value first, so no path through the case can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      len_d       = len_q;
      word_cnt_d  = word_cnt_q;
      word_d      = word_q;
      csum_d      = csum_q;
      tx_data_d   = tx_data_q;
      prog_en_d   = 1'b0;
      prog_addr_d = prog_addr_q;
      prog_data_d = prog_data_q;

      unique case (state_q)
         IDLE, RUN: begin
            if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
               state_d    = LEN;
               byte_cnt_d = 2'd0;
               word_cnt_d = 16'd0;
               csum_d     = 8'd0;
            end
         end

         LEN: begin
            if (bus.rx_valid) begin
               if (byte_cnt_q == 2'd0) begin
                  len_d[7:0] = bus.rx_data;
                  byte_cnt_d = 2'd1;
               end else begin
                  len_d      = len_full;
                  byte_cnt_d = 2'd0;
                  if ((len_full == 16'd0) || (32'(len_full) > MAX_WORDS)) begin
                     state_d   = RESP;
                     tx_data_d = NAK_BYTE;
                  end else begin
                     state_d = DATA;
                  end
               end
            end else if (to_expire) begin
               state_d   = RESP;
               tx_data_d = NAK_BYTE;
            end
         end

         DATA: begin
            if (bus.rx_valid) begin
               csum_d     = csum_q + bus.rx_data;
               word_d     = {bus.rx_data, word_q[23:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  prog_en_d   = 1'b1;
                  prog_data_d = word_full;
                  prog_addr_d = ADDR_BASE + {14'd0, word_cnt_q, 2'b00};
                  word_cnt_d  = word_cnt_inc;
                  if (word_cnt_inc == len_q) begin
                     state_d = CSUM;
                  end
               end
            end else if (to_expire) begin
               state_d   = RESP;
               tx_data_d = NAK_BYTE;
            end
         end

         CSUM: begin
            if (bus.rx_valid) begin
               state_d   = RESP;
               tx_data_d = (bus.rx_data == csum_q) ? ACK_BYTE : NAK_BYTE;
            end else if (to_expire) begin
               state_d   = RESP;
               tx_data_d = NAK_BYTE;
            end
         end

         RESP: begin
            // Incoming bytes are deliberately dropped until the response is taken.
            if (bus.tx_ready) begin
               state_d = (tx_data_q == ACK_BYTE) ? RUN : IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the blocking
   // assignments above are confined to combinational next-state logic.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         byte_cnt_q  <= '0;
         len_q       <= '0;
         word_cnt_q  <= '0;
         word_q      <= '0;
         csum_q      <= '0;
         tx_data_q   <= '0;
         prog_en_q   <= 1'b0;
         prog_addr_q <= '0;
         prog_data_q <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         len_q       <= len_d;
         word_cnt_q  <= word_cnt_d;
         word_q      <= word_d;
         csum_q      <= csum_d;
         tx_data_q   <= tx_data_d;
         prog_en_q   <= prog_en_d;
         prog_addr_q <= prog_addr_d;
         prog_data_q <= prog_data_d;
      end
   end

   // The timer restarts on every byte and on every state change, so each
   // receiving state gets its full idle window from the moment it is entered.
   assign to_clear  = bus.rx_valid || (state_d != state_q);
   assign to_enable = state_is_receiving(state_q);

   loader_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rstn   (rstn),
      .clear  (to_clear),
      .enable (to_enable),
      .expire (to_expire)
   );

   assign bus.tx_valid  = (state_q == RESP);
   assign bus.tx_data   = tx_data_q;
   assign bus.prog_en   = prog_en_q;
   assign bus.prog_addr = prog_addr_q;
   assign bus.prog_data = prog_data_q;
   assign bus.start     = (state_q == RUN);
   assign bus.busy      = state_is_busy(state_q);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: directed frames push expected core writes
// and response bytes; a negedge monitor pops and compares them as the DUT emits.
module tb_uart_prog_loader;

   logic clk;
   logic rstn;

   uart_prog_loader_if bus();

   uart_prog_loader #(
      .ADDR_BASE      (32'h0000_0000),
      .MAX_WORDS      (4096),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } prog_t;

   prog_t       exp_prog[$];
   logic [7:0]  exp_tx[$];

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe and every accepted response is scored.
   always @(negedge clk) begin : monitor
      prog_t      e;
      logic [7:0] t;
      if (bus.prog_en) begin
         if (exp_prog.size() == 0) begin
            check("prog_unexpected", 32'(bus.prog_en), 32'd0);
         end else begin
            e = exp_prog.pop_front();
            check("prog_addr", bus.prog_addr, e.addr);
            check("prog_data", bus.prog_data, e.data);
         end
      end
      if (bus.tx_valid && bus.tx_ready) begin
         if (exp_tx.size() == 0) begin
            check("tx_unexpected", 32'(bus.tx_valid), 32'd0);
         end else begin
            t = exp_tx.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(t));
         end
      end
   end

   // Inputs change at posedge+1; each byte is followed by one idle cycle.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (((exp_prog.size() != 0) || (exp_tx.size() != 0)) && (n < 500)) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(exp_prog.size() + exp_tx.size()), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_prog_en"},   32'(bus.prog_en),  32'd0);
      check({tag, "_prog_addr"}, bus.prog_addr,     32'd0);
      check({tag, "_prog_data"}, bus.prog_data,     32'd0);
      check({tag, "_tx_valid"},  32'(bus.tx_valid), 32'd0);
      check({tag, "_tx_data"},   32'(bus.tx_data),  32'd0);
      check({tag, "_start"},     32'(bus.start),    32'd0);
      check({tag, "_busy"},      32'(bus.busy),     32'd0);
   endtask

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_ready = 1'b1;
      rstn         = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rstn = 1'b1;
      @(posedge clk); #1;

      // Two-word load with correct checksum 0x13+0x93+0x10 = 0xB6.
      exp_prog.push_back('{32'h0000_0000, 32'h0000_0013});
      exp_prog.push_back('{32'h0000_0004, 32'h0010_0093});
      exp_tx.push_back(8'h4B);
      send_byte(8'hA5);
      check("load_busy", 32'(bus.busy), 32'd1);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      send_byte(8'hB6);
      drain("ack_load_drain");
      check("ack_start",     32'(bus.start),    32'd1);
      check("ack_busy",      32'(bus.busy),     32'd0);
      check("hold_prog_en",  32'(bus.prog_en),  32'd0);
      check("hold_prog_addr", bus.prog_addr,    32'h0000_0004);
      check("hold_prog_data", bus.prog_data,    32'h0010_0093);

      // Reload from RUN: sync drops start on the following cycle.
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hA5;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      check("reload_start_fall", 32'(bus.start), 32'd0);
      check("reload_busy",       32'(bus.busy),  32'd1);
      @(posedge clk); #1;

      // Same image, bad checksum: both words still written, NAK, back to IDLE.
      exp_prog.push_back('{32'h0000_0000, 32'h0000_0013});
      exp_prog.push_back('{32'h0000_0004, 32'h0010_0093});
      exp_tx.push_back(8'h45);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      send_byte(8'h00);
      drain("bad_csum_drain");
      check("bad_csum_start", 32'(bus.start), 32'd0);
      check("bad_csum_busy",  32'(bus.busy),  32'd0);

      // Zero length and over-limit length are refused with no writes.
      exp_tx.push_back(8'h45);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      drain("len0_drain");
      check("len0_start", 32'(bus.start), 32'd0);
      exp_tx.push_back(8'h45);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
      drain("len4097_drain");
      check("len4097_busy", 32'(bus.busy), 32'd0);

      // Timeout: NAK response appears 100 cycles after the last byte.
      exp_tx.push_back(8'h45);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h13;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      n = 0;
      while (!bus.tx_valid && (n < 300)) begin
         @(posedge clk); #1;
         n++;
      end
      check("timeout_cycles", 32'(n), 32'd100);
      drain("timeout_drain");
      check("timeout_start", 32'(bus.start), 32'd0);

      // A byte on the expiry cycle wins; the load then completes normally.
      exp_prog.push_back('{32'h0000_0000, 32'h0000_0013});
      exp_tx.push_back(8'h4B);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h13;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h00;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      check("expiry_byte_no_tx", 32'(bus.tx_valid), 32'd0);
      check("expiry_byte_busy",  32'(bus.busy),     32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("expiry_byte_still_no_tx", 32'(bus.tx_valid), 32'd0);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h13);
      drain("expiry_byte_drain");
      check("expiry_byte_start", 32'(bus.start), 32'd1);

      // Backpressured response: stable for 50 cycles while rx bytes are dropped.
      // Checksum 0xAA+0xBB+0xCC+0xDD = 0x30E -> 0x0E.
      exp_prog.push_back('{32'h0000_0000, 32'hDDCC_BBAA});
      exp_tx.push_back(8'h4B);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      bus.tx_ready = 1'b0;
      send_byte(8'h0E);
      n = 0;
      while (!bus.tx_valid && (n < 20)) begin
         @(posedge clk); #1;
         n++;
      end
      check("stall_tx_valid_seen", 32'(bus.tx_valid), 32'd1);
      for (int i = 0; i < 50; i++) begin
         bus.rx_valid = (i % 2 == 0);
         bus.rx_data  = (i % 4 == 0) ? 8'hA5 : 8'h45;
         @(posedge clk); #1;
         check("stall_tx_valid", 32'(bus.tx_valid), 32'd1);
         check("stall_tx_data",  32'(bus.tx_data),  32'h4B);
      end
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_ready = 1'b1;
      drain("stall_drain");
      check("stall_start", 32'(bus.start), 32'd1);
      check("stall_busy",  32'(bus.busy),  32'd0);

      // Reset in the middle of the second word: outputs clear, no response follows.
      exp_prog.push_back('{32'h0000_0000, 32'h4433_2211});
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55);
      #2;
      rstn = 1'b0;
      #1;
      check_outputs_zero("midreset");
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (150) @(posedge clk);
      #1;
      check("midreset_queues", 32'(exp_prog.size() + exp_tx.size()), 32'd0);
      check("midreset_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("midreset_busy",     32'(bus.busy),     32'd0);
      check("midreset_start",    32'(bus.start),    32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter ADDR_BASE, 32'h0000_0000, byte address of the first programmed word.
REQ-002 Parameter MAX_WORDS, 4096, largest accepted word count.
REQ-003 Parameter TIMEOUT_CYCLES, 10_000_000, idle clk cycles allowed between bytes during a load (100 ms at 100 MHz).
REQ-004 clk  input  1  system clock, 100 MHz domain.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
REQ-007 rx_data  input  8  received byte.
REQ-008 tx_valid  output  1  response byte pending.
REQ-009 tx_data  output  8  response byte.
REQ-010 tx_ready  input  1  transmitter accepts tx_data when high with tx_valid.
REQ-011 prog_en  output  1  one-cycle word write strobe to the core.
REQ-012 prog_addr  output  32  byte address of the word being written.
REQ-013 prog_data  output  32  instruction/data word.
REQ-014 start  output  1  core run enable.
REQ-015 busy  output  1  load in progress.

Function
REQ-016 The FSM SHALL have states IDLE, LEN, DATA, CSUM, RESP and RUN.
REQ-017 IDLE: byte SYNC_BYTE (8'hA5) -> LEN; other bytes are ignored.
REQ-018 LEN: 2 bytes, little-endian, give word count N[15:0]; after the 2nd byte, N==0 or N>MAX_WORDS -> RESP with NAK, else -> DATA.
REQ-019 DATA: 4N bytes; each group of 4 bytes forms one word, little-endian (first byte -> bits 7:0).
REQ-020 On the rx_valid cycle of a word's 4th byte, the next cycle SHALL have prog_en=1 for exactly one cycle, with prog_addr=ADDR_BASE+4*k (k = word index from 0) and prog_data set to the assembled word.
REQ-021 prog_addr and prog_data SHALL hold their last values while prog_en=0.
REQ-022 Checksum = 8-bit modulo-256 sum of all 4N data bytes; sync and length bytes are excluded.
REQ-023 After the last data byte -> CSUM; the next byte is compared with the checksum: match -> RESP with ACK (8'h4B), mismatch -> RESP with NAK (8'h45).
REQ-024 RESP: tx_valid=1 with tx_data fixed until the cycle tx_valid&tx_ready; then ACK -> RUN, NAK -> IDLE; rx bytes are ignored in RESP.
REQ-025 start SHALL rise on the cycle RUN is entered and stay high throughout RUN; it is 0 in every other state.
REQ-026 RUN: byte SYNC_BYTE -> start=0 on the next cycle and -> LEN (reload); other bytes are ignored.
REQ-027 Timeout counter: cleared on every rx_valid and on each state entry; in LEN, DATA or CSUM, reaching TIMEOUT_CYCLES-1 with no rx_valid -> RESP with NAK.
REQ-028 When rx_valid coincides with timeout expiry, the byte SHALL win and the timeout is discarded.
REQ-029 busy=1 in LEN, DATA, CSUM and RESP; 0 otherwise.
REQ-030 A NAKed load SHALL leave words already written in place; no rollback.

Reset
REQ-031 rstn low SHALL asynchronously force IDLE; start, prog_en, tx_valid and busy to 0; prog_addr, prog_data, tx_data, counters and checksum to 0.
REQ-032 Reset during any state SHALL abort the load with no further prog_en and no response byte.

Structure
REQ-033 SYNC_BYTE, ACK_BYTE, NAK_BYTE and the loader state enum SHALL live in riscv_defines; the module parameters stay local.
REQ-034 A single sub-module, loader_timeout (a loadable down-counter with clear and expire outputs), is natural; word assembly and checksum stay inline.
REQ-035 The block sits between uart_rx/uart_tx and riscv_cpu_core, and its prog_* and start outputs drive the core directly.

Verification
REQ-036 A5 02 00 | 13 00 00 00 | 93 00 10 00 | B6 -> prog_en at 0x0 = 0x00000013 and at 0x4 = 0x00100093; tx 0x4B; start=1.
REQ-037 Same load with checksum 0x00 -> both writes occur, tx 0x45, start stays 0, state returns to IDLE.
REQ-038 A5 00 00 -> immediate NAK, no prog_en; A5 01 10 (N=4097) -> NAK.
REQ-039 TIMEOUT_CYCLES=100, send A5 01 00 13 then stop -> NAK on cycle 100 after the 13; a byte on the expiry cycle -> no NAK.
REQ-040 Hold tx_ready=0 for 50 cycles in RESP -> tx_valid and tx_data stable and rx bytes dropped; in RUN, send A5 -> start falls, new load accepted; rstn pulse mid-DATA -> outputs 0, no tx.
